// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem initiator.
//   state_e     : sequencer states (idle, bus request in flight, response held)
//   iomem_cmd_t : one queued bus command {wstrb, addr, wdata}; wstrb == 0 is a read
//   GpioBase    : base address of the board GPIO responder
package iomem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StRsp
    } state_e;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iomem_cmd_t;

    localparam int unsigned CmdWidth = 68;
    localparam logic [31:0] GpioBase = 32'h0300_0000;

endpackage

// File: rtl/iomem_cmd_fifo.sv
// Synchronous command FIFO for the iomem initiator.
//   clk_i/rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i      : write wdata_i; caller only pushes when !full_o
//   pop_i       : drop the head entry; caller only pops when !empty_o
//   rdata_o     : head entry (valid while !empty_o)
//   full_o      : registered-count full flag
//   empty_o     : registered-count empty flag
module iomem_cmd_fifo
    import iomem_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  iomem_cmd_t wdata_i,
    input  logic       pop_i,
    output iomem_cmd_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    iomem_cmd_t      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/iomem_initiator.sv
// PicoSoC iomem bus initiator: queues commands, runs one bus transaction at a
// time and returns one response per command, aborting on a bus timeout.
//   CLK, RST                      : clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*        : command stream (wstrb == 0 means read)
//   rsp_valid/ready, rsp_*        : response stream (rsp_timeout flags an abort)
//   iomem_valid/ready, iomem_*    : iomem bus master side
module iomem_initiator
    import iomem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_wstrb,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    iomem_cmd_t fifo_head;
    iomem_cmd_t cmd_in;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    iomem_cmd_t      bus_q, bus_d;
    logic            iomem_valid_q, iomem_valid_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    assign cmd_in    = '{wstrb: cmd_wstrb, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

    iomem_cmd_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (fifo_push),
        .wdata_i (cmd_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_d         = bus_q;
        iomem_valid_d = iomem_valid_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    bus_d         = fifo_head;
                    iomem_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = StBus;
                end
            end
            StBus: begin
                // A completion on the last allowed cycle still wins over the timeout.
                if (iomem_ready) begin
                    rsp_rdata_d   = iomem_rdata;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    iomem_valid_d = 1'b0;
                    state_d       = StRsp;
                end else if (cnt_q == CntLast) begin
                    rsp_rdata_d   = TIMEOUT_RDATA;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    iomem_valid_d = 1'b0;
                    state_d       = StRsp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRsp: begin
                // Passing through IDLE guarantees two low cycles of iomem_valid.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bus_q         <= '0;
            iomem_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_q         <= bus_d;
            iomem_valid_q <= iomem_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign iomem_valid = iomem_valid_q;
    assign iomem_wstrb = bus_q.wstrb;
    assign iomem_addr  = bus_q.addr;
    assign iomem_wdata = bus_q.wdata;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Self-checking bench for iomem_initiator: a behavioural responder with a
// per-transaction ready delay predicts each response from the timeout rule.
module tb_iomem_initiator;
    import iomem_pkg::*;

    localparam int unsigned TO = 15;

    typedef struct packed {
        logic [31:0] rdata;
        logic        to;
    } trsp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [3:0]  cmd_wstrb = '0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        iomem_valid, iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

    int unsigned nchecks = 0, nfail = 0;
    int unsigned cyc = 0;

    // Responder configuration, written only by the main sequence.
    bit          delay_mode = 1'b0;
    int unsigned fixed_delay = 1;
    bit          fixed_rdata_en = 1'b0;
    logic [31:0] fixed_rdata = '0;
    int unsigned stray_req = 0;

    // Observation queues, each appended by exactly one monitor process.
    iomem_cmd_t  bus_q[$], sent_q[$];
    trsp_t       exp_q[$], got_q[$];
    int unsigned vlen_q[$], exp_vlen_q[$], vstart_q[$], ready_cyc_q[$];
    int unsigned rise_q[$], gap_q[$], acc_cyc_q[$];
    int unsigned stab_err = 0, rsp_stab_err = 0, stray_ack = 0;

    iomem_initiator #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_RDATA  (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wstrb   (cmd_wstrb),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Responder: ready pulses after 'delay' cycles of valid; never if valid drops first.
    initial begin : responder
        bit          act = 0, seen = 0;
        int unsigned cnt = 0, len = 0, dly = 0, gap = 0;
        logic [31:0] rd = '0;
        iomem_cmd_t  cur;
        trsp_t       e;
        iomem_ready = 1'b0;
        iomem_rdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            iomem_ready = 1'b0;
            if (stray_req != stray_ack) begin
                stray_ack++;
                iomem_ready = 1'b1;
                iomem_rdata = $urandom;
            end
            if (iomem_valid === 1'b1) begin
                if (!act) begin
                    act = 1;
                    cnt = 0;
                    len = 0;
                    cur = '{wstrb: iomem_wstrb, addr: iomem_addr, wdata: iomem_wdata};
                    bus_q.push_back(cur);
                    vstart_q.push_back(cyc);
                    if (seen) gap_q.push_back(gap);
                    seen = 1;
                    dly  = delay_mode ? $urandom_range(0, 20) : fixed_delay;
                    rd   = fixed_rdata_en ? fixed_rdata : $urandom;
                    if (dly <= TO - 1) begin
                        e.rdata = rd;
                        e.to    = 1'b0;
                        exp_vlen_q.push_back(dly + 1);
                    end else begin
                        e.rdata = 32'h0;
                        e.to    = 1'b1;
                        exp_vlen_q.push_back(TO);
                    end
                    exp_q.push_back(e);
                end else if ({iomem_wstrb, iomem_addr, iomem_wdata} !== cur) begin
                    stab_err++;
                end
                len++;
                if (cnt == dly) begin
                    iomem_ready = 1'b1;
                    iomem_rdata = rd;
                    ready_cyc_q.push_back(cyc);
                end
                cnt++;
            end else begin
                if (act) begin
                    act = 0;
                    vlen_q.push_back(len);
                    gap = 0;
                end
                gap++;
            end
        end
    end

    // Command/response handshake monitor, sampled mid-cycle.
    initial begin : monitor
        bit    pv = 0, phs = 0;
        trsp_t pr = '0;
        trsp_t cr;
        forever begin
            @(negedge CLK);
            cr = '{rdata: rsp_rdata, to: rsp_timeout};
            if (cmd_valid && cmd_ready === 1'b1) begin
                sent_q.push_back('{wstrb: cmd_wstrb, addr: cmd_addr, wdata: cmd_wdata});
                acc_cyc_q.push_back(cyc);
            end
            if (rsp_valid === 1'b1 && !pv) rise_q.push_back(cyc);
            if (pv && !phs && (rsp_valid !== 1'b1 || cr !== pr)) rsp_stab_err++;
            if (rsp_valid === 1'b1 && rsp_ready) got_q.push_back(cr);
            pv  = (rsp_valid === 1'b1);
            phs = pv && rsp_ready;
            pr  = cr;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input iomem_cmd_t c, output bit ok);
        cmd_valid = 1'b1;
        cmd_wstrb = c.wstrb;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (cmd_ready === 1'b1) ok = 1;
            tick();
            if (ok) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned n, input int unsigned base, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (got_q.size() >= base + n) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        nchecks++;
        if ({iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, rsp_valid, rsp_rdata,
             rsp_timeout} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs got v=%b ws=%h a=%h wd=%h rv=%b rd=%h to=%b exp all 0",
                     iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, rsp_valid,
                     rsp_rdata, rsp_timeout);
        end
        RST = 1'b0;
        tick();
        nchecks++;
        if (cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        end
        nchecks++;
        if (iomem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_idle got v=%b rv=%b exp 0 0", iomem_valid, rsp_valid);
        end
    endtask

    task automatic test_write();
        int unsigned b = bus_q.size(), g = got_q.size(), a = acc_cyc_q.size();
        int unsigned r = rise_q.size(), rc = ready_cyc_q.size(), v = vlen_q.size();
        int unsigned s = stab_err;
        iomem_cmd_t c = '{wstrb: 4'hF, addr: GpioBase, wdata: 32'h0403_0201};
        bit ok;
        delay_mode = 0; fixed_delay = 1; fixed_rdata_en = 0; rsp_ready = 1'b1;
        send_cmd(c, ok);
        wait_rsp(1, g, ok);
        nchecks++;
        if (!ok) begin nfail++; $display("FAIL write_rsp got=none exp=1 response"); return; end
        nchecks++;
        if (vstart_q[b] - acc_cyc_q[a] !== 2) begin
            nfail++;
            $display("FAIL write_latency got=%0d exp=2", vstart_q[b] - acc_cyc_q[a]);
        end
        nchecks++;
        if (bus_q[b] !== c) begin
            nfail++; $display("FAIL write_bus got=%h exp=%h", bus_q[b], c);
        end
        nchecks++;
        if (vlen_q[v] !== 2) begin
            nfail++; $display("FAIL write_valid_len got=%0d exp=2", vlen_q[v]);
        end
        nchecks++;
        if (got_q[g] !== exp_q[b] || got_q[g].to !== 1'b0) begin
            nfail++; $display("FAIL write_rsp_data got=%h exp=%h", got_q[g], exp_q[b]);
        end
        nchecks++;
        if (rise_q[r] - ready_cyc_q[rc] !== 1) begin
            nfail++;
            $display("FAIL write_rsp_latency got=%0d exp=1", rise_q[r] - ready_cyc_q[rc]);
        end
        nchecks++;
        if (stab_err !== s) begin
            nfail++; $display("FAIL write_stable got=%0d exp=%0d", stab_err, s);
        end
    endtask

    task automatic test_read();
        int unsigned b = bus_q.size(), g = got_q.size(), v = vlen_q.size(), s = stab_err;
        iomem_cmd_t c = '{wstrb: 4'h0, addr: GpioBase, wdata: $urandom};
        bit ok;
        delay_mode = 0; fixed_delay = 3; fixed_rdata_en = 1; fixed_rdata = 32'hA5C3_0F81;
        rsp_ready = 1'b1;
        send_cmd(c, ok);
        wait_rsp(1, g, ok);
        nchecks++;
        if (!ok) begin nfail++; $display("FAIL read_rsp got=none exp=1 response"); return; end
        nchecks++;
        if (bus_q[b] !== c || stab_err !== s) begin
            nfail++; $display("FAIL read_bus got=%h stab=%0d exp=%h stab=%0d", bus_q[b],
                              stab_err, c, s);
        end
        nchecks++;
        if (got_q[g].rdata !== 32'hA5C3_0F81 || got_q[g].to !== 1'b0) begin
            nfail++; $display("FAIL read_rsp_data got=%h exp=a5c30f81/0", got_q[g]);
        end
        nchecks++;
        if (vlen_q[v] !== 4) begin
            nfail++; $display("FAIL read_valid_len got=%0d exp=4", vlen_q[v]);
        end
        fixed_rdata_en = 0;
    endtask

    task automatic test_timeout();
        int unsigned b = bus_q.size(), g = got_q.size(), v = vlen_q.size(), r = rise_q.size();
        int unsigned rs = rsp_stab_err;
        iomem_cmd_t c = '{wstrb: 4'h0, addr: GpioBase + 32'h4, wdata: '0};
        bit ok, seen;
        delay_mode = 0; fixed_delay = 1000; rsp_ready = 1'b0;
        send_cmd(c, ok);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (rise_q.size() > r) begin seen = 1; break; end
            tick();
        end
        nchecks++;
        if (!seen) begin nfail++; $display("FAIL timeout_rsp got=none exp=response"); return; end
        nchecks++;
        if (vlen_q[v] !== TO) begin
            nfail++; $display("FAIL timeout_valid_len got=%0d exp=%0d", vlen_q[v], TO);
        end
        // Late ready lands while the timed-out response is still being held.
        @(negedge CLK);
        @(negedge CLK);
        stray_req++;
        repeat (3) tick();
        rsp_ready = 1'b1;
        wait_rsp(1, g, ok);
        repeat (10) tick();
        nchecks++;
        if (!ok || got_q[g] !== '{rdata: 32'h0, to: 1'b1}) begin
            nfail++; $display("FAIL timeout_rsp_data got=%h exp=000000001", got_q[g]);
        end
        nchecks++;
        if (got_q.size() !== g + 1 || bus_q.size() !== b + 1 || rsp_stab_err !== rs) begin
            nfail++;
            $display("FAIL timeout_stray got rsps=%0d bus=%0d stab=%0d exp %0d %0d %0d",
                     got_q.size() - g, bus_q.size() - b, rsp_stab_err, 1, 1, rs);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned b = bus_q.size(), g = got_q.size(), gb = gap_q.size(), s = stab_err;
        iomem_cmd_t  cmds[6];
        logic [5:0]  rdy;
        int unsigned k = 0, mingap = 1000;
        bit ok;
        delay_mode = 0; fixed_delay = 0; rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmds[i] = '{wstrb: 4'($urandom), addr: GpioBase | ($urandom & 32'hFC),
                        wdata: $urandom};
        end
        cmd_valid = 1'b1;
        for (int cy = 0; cy < 6; cy++) begin
            {cmd_wstrb, cmd_addr, cmd_wdata} = cmds[k];
            @(negedge CLK);
            rdy[cy] = cmd_ready;
            if (cmd_ready === 1'b1) k++;
            tick();
        end
        nchecks++;
        if (rdy !== 6'b01_1111 || k !== 5) begin
            nfail++; $display("FAIL b2b_accept got rdy=%b n=%0d exp rdy=011111 n=5", rdy, k);
        end
        @(negedge CLK);
        nchecks++;
        if (cmd_ready !== 1'b0) begin
            nfail++; $display("FAIL b2b_full_hold got=%b exp=0", cmd_ready);
        end
        tick();
        rsp_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (cmd_ready === 1'b1) ok = 1;
            tick();
            if (ok) break;
        end
        cmd_valid = 1'b0;
        wait_rsp(6, g, ok);
        nchecks++;
        if (!ok) begin nfail++; $display("FAIL b2b_rsp got=%0d exp=6", got_q.size() - g); return; end
        for (int i = 0; i < 6; i++) begin
            nchecks++;
            if (bus_q[b+i] !== cmds[i] || got_q[g+i] !== exp_q[b+i]) begin
                nfail++;
                $display("FAIL b2b_order[%0d] got bus=%h rsp=%h exp bus=%h rsp=%h", i,
                         bus_q[b+i], got_q[g+i], cmds[i], exp_q[b+i]);
            end
        end
        for (int i = gb; i < gap_q.size(); i++) if (gap_q[i] < mingap) mingap = gap_q[i];
        nchecks++;
        if (mingap < 2 || stab_err !== s) begin
            nfail++; $display("FAIL b2b_gap got min=%0d stab=%0d exp >=2 stab=%0d", mingap,
                              stab_err, s);
        end
    endtask

    task automatic test_reset_mid_bus();
        int unsigned b = bus_q.size(), g = got_q.size();
        iomem_cmd_t c;
        bit ok;
        delay_mode = 0; fixed_delay = 1000; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c = '{wstrb: 4'($urandom), addr: $urandom, wdata: $urandom};
            send_cmd(c, ok);
        end
        nchecks++;
        if (iomem_valid !== 1'b1) begin
            nfail++; $display("FAIL rstmid_setup got valid=%b exp=1", iomem_valid);
        end
        RST = 1'b1;
        tick();
        nchecks++;
        if (iomem_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            nfail++; $display("FAIL rstmid_outputs got v=%b rv=%b cr=%b exp 0 0 1",
                              iomem_valid, rsp_valid, cmd_ready);
        end
        RST = 1'b0;
        fixed_delay = 1;
        repeat (30) tick();
        nchecks++;
        if (got_q.size() !== g || bus_q.size() !== b + 1) begin
            nfail++; $display("FAIL rstmid_flush got rsps=%0d bus=%0d exp 0 1",
                              got_q.size() - g, bus_q.size() - b);
        end
    endtask

    task automatic test_random();
        localparam int unsigned N = 1000;
        int unsigned b = bus_q.size(), g = got_q.size(), sa = sent_q.size(), v = vlen_q.size();
        int unsigned gb = gap_q.size(), s = stab_err, rs = rsp_stab_err, mingap = 1000;
        bit send_ok = 1;
        delay_mode = 1; fixed_rdata_en = 0;
        fork
            begin
                iomem_cmd_t c;
                bit ok;
                for (int i = 0; i < N; i++) begin
                    c = '{wstrb: 4'($urandom), addr: $urandom, wdata: $urandom};
                    if ($urandom_range(0, 3) == 0) tick();
                    send_cmd(c, ok);
                    if (!ok) begin send_ok = 0; break; end
                end
            end
            begin
                for (int i = 0; i < 60000 && got_q.size() < g + N; i++) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        rsp_ready = 1'b1;
        nchecks++;
        if (!send_ok || got_q.size() !== g + N) begin
            nfail++; $display("FAIL rand_count got sent_ok=%0d rsps=%0d exp 1 %0d", send_ok,
                              got_q.size() - g, N);
            return;
        end
        for (int i = 0; i < N; i++) begin
            nchecks++;
            if (bus_q[b+i] !== sent_q[sa+i] || got_q[g+i] !== exp_q[b+i] ||
                vlen_q[v+i] !== exp_vlen_q[b+i]) begin
                nfail++;
                $display("FAIL rand_txn[%0d] got bus=%h rsp=%h len=%0d exp bus=%h rsp=%h len=%0d",
                         i, bus_q[b+i], got_q[g+i], vlen_q[v+i], sent_q[sa+i], exp_q[b+i],
                         exp_vlen_q[b+i]);
            end
        end
        for (int i = gb; i < gap_q.size(); i++) if (gap_q[i] < mingap) mingap = gap_q[i];
        nchecks++;
        if (mingap < 2 || stab_err !== s || rsp_stab_err !== rs) begin
            nfail++; $display("FAIL rand_protocol got gap=%0d stab=%0d rstab=%0d exp >=2 %0d %0d",
                              mingap, stab_err, rsp_stab_err, s, rs);
        end
    endtask

    initial begin : main
        test_reset();
        test_write();
        repeat (3) tick();
        test_read();
        repeat (3) tick();
        test_timeout();
        repeat (3) tick();
        test_back_to_back();
        repeat (3) tick();
        test_reset_mid_bus();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
